// File: rtl/dht_disp_pkg.sv
// Shared definitions for the DHT display path: converter FSM states,
// overflow digit code, display slot numbering and double-dabble length.
package dht_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_H,
        ST_CONV_T,
        ST_COMMIT
    } state_e;

    localparam logic [3:0] OVF_CODE_DEFAULT = 4'hE;

    localparam int unsigned DIG_T1  = 1;
    localparam int unsigned DIG_T10 = 2;
    localparam int unsigned DIG_H1  = 3;
    localparam int unsigned DIG_H10 = 4;

    localparam int unsigned ITER_CNT = 8;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the next binary bit in at the LSB.
module bcd_dd_step (
    input  logic [11:0] acc_i,
    input  logic        bit_i,
    output logic [11:0] acc_o
);

    logic [11:0] adj;

    always_comb begin
        adj = acc_i;
        for (int unsigned n = 0; n < 3; n++) begin
            if (acc_i[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = acc_i[n*4 +: 4] + 4'd3;
            end
        end
        // Hundreds never exceeds 2 for an 8-bit input, so the dropped MSB is always 0.
        acc_o = (adj << 1) | {11'd0, bit_i};
    end

endmodule

// File: rtl/dht_bcd_formatter.sv
// Converts DHT11 humidity/temperature bytes to BCD digit pairs for the
// 7-segment scanner; all four digits and the overflow flags commit together.
module dht_bcd_formatter
    import dht_disp_pkg::*;
#(
    parameter logic [3:0] OVF_CODE = OVF_CODE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] hum,
    input  logic [7:0] temp,
    output logic [3:0] s1_data,
    output logic [3:0] s2_data,
    output logic [3:0] s3_data,
    output logic [3:0] s4_data,
    output logic       busy,
    output logic       done,
    output logic [1:0] ovf
);

    localparam logic [2:0] LAST_ITER = 3'(ITER_CNT - 1);

    state_e      state_q, state_d;
    logic [11:0] acc_q, acc_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  temp_q, temp_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] hum_bcd_q, hum_bcd_d;
    logic [3:0]  dig_q [1:4];
    logic [3:0]  dig_d [1:4];
    logic [1:0]  ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [11:0] step_acc;

    bcd_dd_step u_step (
        .acc_i (acc_q),
        .bit_i (shreg_q[7]),
        .acc_o (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        shreg_d   = shreg_q;
        temp_d    = temp_q;
        cnt_d     = cnt_q;
        hum_bcd_d = hum_bcd_q;
        dig_d     = dig_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = hum;
                    temp_d  = temp;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CONV_H;
                end
            end
            ST_CONV_H: begin
                acc_d   = step_acc;
                shreg_d = {shreg_q[6:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    // Humidity result parks here while the shared accumulator converts temp.
                    hum_bcd_d = step_acc;
                    acc_d     = '0;
                    shreg_d   = temp_q;
                    state_d   = ST_CONV_T;
                end
            end
            ST_CONV_T: begin
                acc_d   = step_acc;
                shreg_d = {shreg_q[6:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (hum_bcd_q[11:8] != 4'd0) begin
                    dig_d[DIG_H10] = OVF_CODE;
                    dig_d[DIG_H1]  = OVF_CODE;
                    ovf_d[1]       = 1'b1;
                end else begin
                    dig_d[DIG_H10] = hum_bcd_q[7:4];
                    dig_d[DIG_H1]  = hum_bcd_q[3:0];
                    ovf_d[1]       = 1'b0;
                end
                if (acc_q[11:8] != 4'd0) begin
                    dig_d[DIG_T10] = OVF_CODE;
                    dig_d[DIG_T1]  = OVF_CODE;
                    ovf_d[0]       = 1'b1;
                end else begin
                    dig_d[DIG_T10] = acc_q[7:4];
                    dig_d[DIG_T1]  = acc_q[3:0];
                    ovf_d[0]       = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            shreg_q   <= '0;
            temp_q    <= '0;
            cnt_q     <= '0;
            hum_bcd_q <= '0;
            for (int unsigned i = 1; i <= 4; i++) begin
                dig_q[i] <= '0;
            end
            ovf_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            shreg_q   <= shreg_d;
            temp_q    <= temp_d;
            cnt_q     <= cnt_d;
            hum_bcd_q <= hum_bcd_d;
            for (int unsigned i = 1; i <= 4; i++) begin
                dig_q[i] <= dig_d[i];
            end
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign s1_data = dig_q[DIG_T1];
    assign s2_data = dig_q[DIG_T10];
    assign s3_data = dig_q[DIG_H1];
    assign s4_data = dig_q[DIG_H10];
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_dht_bcd_formatter.sv
// Directed bench for dht_bcd_formatter: hand-computed digit frames,
// 17-edge latency, ignored strobes and asynchronous reset mid-conversion.
module tb_dht_bcd_formatter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] hum;
    logic [7:0] temp;
    logic [3:0] s1_data, s2_data, s3_data, s4_data;
    logic       busy, done;
    logic [1:0] ovf;

    int unsigned checks;
    int unsigned errors;

    logic [15:0] last_frame;
    logic [1:0]  last_ovf;

    dht_bcd_formatter #(.OVF_CODE(4'hE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .hum      (hum),
        .temp     (temp),
        .s1_data  (s1_data),
        .s2_data  (s2_data),
        .s3_data  (s3_data),
        .s4_data  (s4_data),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] frame();
        return {s4_data, s3_data, s2_data, s1_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full conversion; optional extra strobe (hum=88,temp=88) before edge inj.
    task automatic convert(input logic [7:0] h, input logic [7:0] t, input int inj,
                           input logic [15:0] exp_frame, input logic [1:0] exp_ovf);
        in_valid = 1'b1;
        hum      = h;
        temp     = t;
        step();
        in_valid = 1'b0;
        hum      = 8'hA5;
        temp     = 8'h5A;
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        check_eq("done_after_accept", 32'(done), 32'd0);
        for (int e = 1; e <= 16; e++) begin
            if (e == inj) begin
                in_valid = 1'b1;
                hum      = 8'd88;
                temp     = 8'd88;
            end
            step();
            in_valid = 1'b0;
            check_eq("busy_during", 32'(busy), 32'd1);
            check_eq("done_during", 32'(done), 32'd0);
            check_eq("frame_held", 32'(frame()), 32'(last_frame));
            check_eq("ovf_held", 32'(ovf), 32'(last_ovf));
        end
        step();
        check_eq("frame_commit", 32'(frame()), 32'(exp_frame));
        check_eq("ovf_commit", 32'(ovf), 32'(exp_ovf));
        check_eq("done_commit", 32'(done), 32'd1);
        check_eq("busy_commit", 32'(busy), 32'd0);
        step();
        check_eq("done_pulse_end", 32'(done), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("frame_stable", 32'(frame()), 32'(exp_frame));
        last_frame = exp_frame;
        last_ovf   = exp_ovf;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        last_frame = 16'h0000;
        last_ovf   = 2'b00;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        hum        = '0;
        temp       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check_eq("reset_frame", 32'(frame()), 32'h0000);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_ovf", 32'(ovf), 32'd0);

        convert(8'd45,  8'd23,  0, 16'h4523, 2'b00);
        convert(8'd99,  8'd0,   0, 16'h9900, 2'b00);
        convert(8'd7,   8'd30,  5, 16'h0730, 2'b00);
        convert(8'd100, 8'd255, 0, 16'hEEEE, 2'b11);

        // Reset in the middle of a 61/12 conversion.
        in_valid = 1'b1;
        hum      = 8'd61;
        temp     = 8'd12;
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 9; e++) step();
        check_eq("busy_before_rst", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_frame", 32'(frame()), 32'h0000);
        check_eq("rst_async_busy", 32'(busy), 32'd0);
        check_eq("rst_async_done", 32'(done), 32'd0);
        check_eq("rst_async_ovf", 32'(ovf), 32'd0);
        for (int e = 0; e < 10; e++) begin
            step();
            check_eq("rst_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            check_eq("post_rst_no_done", 32'(done), 32'd0);
            check_eq("post_rst_frame", 32'(frame()), 32'h0000);
        end
        last_frame = 16'h0000;
        last_ovf   = 2'b00;

        convert(8'd61, 8'd12, 0, 16'h6112, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
